// File: rtl/param_stack.sv
// Parametrised LIFO with a registered top-of-stack, occupancy count, replace-top on
// simultaneous push+pop, sticky overflow/underflow flags and a synchronous clear.
module param_stack #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1,
  localparam int unsigned CNT_W     = f_clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] TOP,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  function automatic int unsigned f_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

  localparam int unsigned     PTR_W   = f_clog2(DEPTH);
  localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] L_AF    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] L_AE    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TWO   = CNT_W'(2);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_top;
  logic [CNT_W-1:0]      r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic                  r_ovf;
  logic                  r_udf;

  logic [DATA_WIDTH-1:0] w_top_d;
  logic [CNT_W-1:0]      w_count_d;
  logic                  w_ovf_d;
  logic                  w_udf_d;
  logic                  w_wr_en;
  logic [PTR_W-1:0]      w_wr_idx;
  logic [PTR_W-1:0]      w_rd_idx;

  // Entry just below the current top; only consulted when at least two entries exist.
  assign w_rd_idx = PTR_W'(r_count - L_TWO);

  always_comb begin
    w_top_d   = r_top;
    w_count_d = r_count;
    w_ovf_d   = r_ovf;
    w_udf_d   = r_udf;
    w_wr_en   = 1'b0;
    w_wr_idx  = PTR_W'(r_count);
    if (CLEAR) begin
      w_top_d   = '0;
      w_count_d = '0;
      w_ovf_d   = 1'b0;
      w_udf_d   = 1'b0;
    end else if (PUSH && POP) begin
      w_wr_en = 1'b1;
      w_top_d = DATA_IN;
      if (r_empty) begin
        // Pop on an empty stack is ignored; the push goes ahead.
        w_wr_idx  = '0;
        w_count_d = L_ONE;
      end else begin
        w_wr_idx = PTR_W'(r_count - L_ONE);
      end
    end else if (PUSH) begin
      if (r_full) begin
        w_ovf_d = 1'b1;
      end else begin
        w_wr_en   = 1'b1;
        w_wr_idx  = PTR_W'(r_count);
        w_count_d = r_count + L_ONE;
        w_top_d   = DATA_IN;
      end
    end else if (POP) begin
      if (r_empty) begin
        w_udf_d = 1'b1;
      end else if (r_count == L_ONE) begin
        w_count_d = '0;
        w_top_d   = '0;
      end else begin
        w_count_d = r_count - L_ONE;
        w_top_d   = r_mem[w_rd_idx];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_top   <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= (AF_THRESH == 0);
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_top   <= w_top_d;
      r_count <= w_count_d;
      r_full  <= (w_count_d == L_DEPTH);
      r_empty <= (w_count_d == '0);
      r_af    <= (w_count_d >= L_AF);
      r_ae    <= (w_count_d <= L_AE);
      r_ovf   <= w_ovf_d;
      r_udf   <= w_udf_d;
    end
  end

  // Storage is deliberately not reset; a reset cycle simply suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && w_wr_en) begin
      r_mem[w_wr_idx] <= DATA_IN;
    end
  end

  assign TOP          = r_top;
  assign COUNT        = r_count;
  assign FULL         = r_full;
  assign EMPTY        = r_empty;
  assign ALMOST_FULL  = r_af;
  assign ALMOST_EMPTY = r_ae;
  assign OVERFLOW     = r_ovf;
  assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_param_stack.sv
// Bench for param_stack (DEPTH=4): queue-based reference model feeding a scoreboard of
// expected post-edge states, plus directed checks of the documented scenarios.
module tb_param_stack;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef struct packed {
    logic [DW-1:0]    top;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             af;
    logic             ae;
    logic             ovf;
    logic             udf;
  } st_t;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             CLEAR = 1'b0;
  logic             PUSH = 1'b0;
  logic             POP = 1'b0;
  logic [DW-1:0]    DATA_IN = '0;
  logic [DW-1:0]    TOP;
  logic [CNT_W-1:0] COUNT;
  logic             FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_q [$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;
  st_t           exp_q [$];

  param_stack #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLEAR        (CLEAR),
    .PUSH         (PUSH),
    .POP          (POP),
    .DATA_IN      (DATA_IN),
    .TOP          (TOP),
    .COUNT        (COUNT),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic st_t obs();
    return {TOP, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW};
  endfunction

  function automatic void model_apply(input logic p, input logic po, input logic c,
                                      input logic r, input logic [DW-1:0] d);
    if (r || c) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (p && po) begin
      if (m_q.size() == 0) m_q.push_back(d);
      else m_q[m_q.size()-1] = d;
    end else if (p) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end else if (po) begin
      if (m_q.size() > 0) void'(m_q.pop_back());
      else m_udf = 1'b1;
    end
  endfunction

  function automatic st_t model_state();
    st_t s;
    int  n;
    n       = m_q.size();
    s.top   = (n > 0) ? m_q[n-1] : '0;
    s.count = CNT_W'(n);
    s.full  = (n == DEPTH);
    s.empty = (n == 0);
    s.af    = (n >= 3);
    s.ae    = (n <= 1);
    s.ovf   = m_ovf;
    s.udf   = m_udf;
    return s;
  endfunction

  // Drive one cycle of stimulus, queue the expected result, return #1 after the edge.
  task automatic drive(input logic p, input logic po, input logic c, input logic r,
                       input logic [DW-1:0] d);
    PUSH = p; POP = po; CLEAR = c; RST = r; DATA_IN = d;
    model_apply(p, po, c, r, d);
    exp_q.push_back(model_state());
    @(posedge CLK);
    #1;
    PUSH = 1'b0; POP = 1'b0; CLEAR = 1'b0; RST = 1'b0;
  endtask

  task automatic test_reset();
    st_t e, o;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got %h required %h", o, e);
      end
    end
    checks++;
    if ({TOP, COUNT, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW}
        !== {8'h00, 3'd0, 6'b101000}) begin
      errors++;
      $display("FAIL reset_const: got top=%h cnt=%0d e=%b f=%b required 00 0 1 0", TOP,
               COUNT, EMPTY, FULL);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    st_t e, o;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fill[%0d]: got %h required %h", i, o, e);
      end
      checks++;
      if (TOP !== vals[i] || COUNT !== CNT_W'(i + 1) || ALMOST_FULL !== (i >= 2)
          || FULL !== (i == 3) || EMPTY !== 1'b0) begin
        errors++;
        $display("FAIL fill_const[%0d]: got top=%h cnt=%0d af=%b f=%b e=%b", i, TOP, COUNT,
                 ALMOST_FULL, FULL, EMPTY);
      end
    end
  endtask

  task automatic test_overflow_drain();
    logic [DW-1:0] tops [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
    st_t e, o;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || TOP !== 8'h44 || COUNT !== 3'd4 || OVERFLOW !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got %h required %h", o, e);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e || TOP !== tops[i] || COUNT !== CNT_W'(3 - i) || OVERFLOW !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d]: got %h required %h", i, o, e);
      end
    end
  endtask

  task automatic test_underflow_clear();
    st_t e, o;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || UNDERFLOW !== 1'b1 || COUNT !== 3'd0 || TOP !== 8'h00) begin
      errors++;
      $display("FAIL underflow: got %h required %h", o, e);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || UNDERFLOW !== 1'b0 || OVERFLOW !== 1'b0 || COUNT !== 3'd0) begin
      errors++;
      $display("FAIL clear: got %h required %h", o, e);
    end
  endtask

  task automatic test_replace();
    st_t e, o;
    logic [DW-1:0] d  [6] = '{8'hA1, 8'hA2, 8'hB7, 8'h00, 8'h00, 8'hC3};
    logic          p  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          po [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] t  [6] = '{8'hA1, 8'hA2, 8'hB7, 8'hA1, 8'h00, 8'hC3};
    logic [2:0]    n  [6] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0, 3'd1};
    for (int i = 0; i < 6; i++) begin
      drive(p[i], po[i], 1'b0, 1'b0, d[i]);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e || TOP !== t[i] || COUNT !== n[i] || UNDERFLOW !== 1'b0) begin
        errors++;
        $display("FAIL replace[%0d]: got %h required %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    st_t e, o;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h60 + i));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
    for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e || COUNT !== 3'd0 || TOP !== 8'h00 || EMPTY !== 1'b1
        || ALMOST_EMPTY !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got %h required %h", o, e);
    end
  endtask

  task automatic test_random();
    st_t e, o;
    int  r;
    int  bad = 0;
    int  both = 0;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 199);
      drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), (r < 3), (r == 3),
            DW'($urandom));
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        errors++;
        bad++;
        if (bad <= 10) $display("FAIL random[%0d]: got %h required %h", i, o, e);
      end
      checks++;
      if (FULL && EMPTY) begin
        errors++;
        both++;
        if (both <= 10) $display("FAIL full_and_empty[%0d]: got 1 required 0", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow_clear();
    test_replace();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
